cam_capture: RTL and testbench
==============================

# cam_capture

Camera-side capture core for the OV7670-style parallel sensor interface: generates the sensor master clock, oversamples Pclk/Href/Vsyn/data in the system clock domain and captures one complete frame per capture request into an on-chip byte FIFO. It sits directly upstream of the Wishbone camera peripheral, which drives `capture` and `rd` from its registers and reads `data_out`.

## Interface
- `AW`, 10, FIFO address width; depth = 2^AW bytes.
- `XCLK_HALF`, 2, clk cycles per Xclk half-period (Xclk = clk / (2·XCLK_HALF)); must be ≥ 1.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `capture` in 1: capture request level; the rising edge arms a one-frame capture.
- `rd` in 1: pop request level; each rising edge pops one byte.
- `Href` in 1: sensor line-valid, asynchronous.
- `Vsyn` in 1: sensor vertical sync, asynchronous, high pulse between frames.
- `Pclk` in 1: sensor pixel clock, asynchronous; frequency ≤ clk/4.
- `data` in 8: sensor pixel byte, valid on Pclk rising edge.
- `data_out` out 8: last popped byte (registered).
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `level` out AW+1: bytes stored.
- `overflow` out 1: sticky; at least one byte dropped since the last capture start.
- `busy` out 1: high in WAIT_VS or CAPTURE.
- `done` out 1: high in DONE.
- `Xclk` out 1: sensor master clock.
- `reset` out 1: sensor reset, active-low.
- `PWDN` out 1: sensor power-down, active-high.

## Operation
- Synchronizers: Pclk, Href, Vsyn and data each pass through 2 flops (s1, s2); Pclk and Vsyn get a third flop (s3). `pclk_rise` = Pclk s2 & ~s3. `vs_rise` / `vs_fall` are derived the same way from Vsyn. The byte written is data s2 and is qualified by Href s2.
- `capture` and `rd` are edge-detected with one register each; a level held high triggers only once.
- FSM states: IDLE, WAIT_VS, CAPTURE, DONE.
  - IDLE → WAIT_VS on a capture rising edge. On the same edge the write and read pointers are cleared and `overflow` is cleared.
  - WAIT_VS → CAPTURE on `vs_fall`. This guarantees that a whole frame is captured from its first line.
  - CAPTURE: on `pclk_rise` with Href s2 = 1, write one byte. If `full`, drop the byte and set `overflow`. CAPTURE → DONE on `vs_rise`.
  - DONE → IDLE when `capture` is low. A capture rising edge in any non-IDLE state is ignored.
- FIFO: 2^AW × 8 memory, pointers AW+1 bits wide that wrap naturally. `full` = level == 2^AW.
  - Pop: on an `rd` rising edge with `!empty`, set `data_out` to mem[rptr] and increment rptr. A pop while empty is ignored and `data_out` holds its value.
  - A write and a pop in the same cycle both take effect and `level` is unchanged. Popping is allowed in every state, including during CAPTURE.
- Xclk: free-running divider. It toggles every XCLK_HALF clk cycles, in all states.
- Camera control: `reset` = 0 and `PWDN` = 1 while `rst` is asserted. From the first clk edge after `rst` deasserts, `reset` = 1 and `PWDN` = 0.

## Timing
- Reset values: `data_out` = 0, `empty` = 1, `full` = 0, `level` = 0, `overflow` = 0, `busy` = 0, `done` = 0, `Xclk` = 0, `reset` = 0, `PWDN` = 1. FSM = IDLE, pointers = 0, all synchronizer and edge flops = 0.
- Asserting `rst` mid-frame aborts immediately. FIFO contents are discarded (pointers cleared).
- Write latency: Pclk high is first sampled at edge k; the byte is in memory and `level` increments at edge k+2.
- Pop latency: `rd` is sampled high at edge k; `data_out`, `level` and `empty` update at edge k+1.
- Capture edge: sampled at edge k; the FSM is in WAIT_VS and pointers are cleared at edge k+1.
- Vsyn edge: sampled at edge k; the state change takes effect at edge k+2.
- `overflow` sets on the same edge at which the write would have occurred.
- Xclk: first rising edge at the XCLK_HALF-th clk edge after reset release. Duty cycle is 50%.

## Test plan
- Reset: assert `rst` asynchronously mid-CAPTURE with level = 5 → outputs immediately equal the reset values listed above.
- Single frame, AW = 4: capture pulse; Vsyn high→low; 2 lines × 4 bytes (0x10..0x17) with Href high, Pclk = clk/4; Vsyn rise → `done` = 1, level = 8. Eight rd pulses → `data_out` = 0x10..0x17 in order, then `empty` = 1.
- Gating:
  - Bytes presented with Href low, or before the first `vs_fall` → not stored (level = 0).
  - A second capture pulse during CAPTURE → ignored.
- Overflow, AW = 4: a 20-byte line → level = 16, `full` = 1, `overflow` = 1, first 16 bytes stored.
  - A new capture (after `capture` returns low) clears `overflow` and `level`.
- Simultaneous write and pop: rd rising edge aligned to the write edge at level = 3 → level stays 3 and `data_out` = the oldest byte. A pop when empty leaves `data_out` unchanged.
- Xclk, XCLK_HALF = 3: period = 6 clk, high for 3 clk. `reset` = 1 and `PWDN` = 0 one edge after `rst` release.

Source files
------------

// File: rtl/cam_capture.sv
// cam_capture: capture core for an OV7670-style parallel camera.
// It generates the sensor master clock and drives the sensor control pins.
// It oversamples the asynchronous sensor signals in the clk domain. Each
// capture request stores exactly one whole frame into a 2^AW-byte FIFO.
//
// Ports:
//   clk, rst        system clock; asynchronous active-high reset
//   capture         capture request level (rising edge arms one frame)
//   rd              pop request level (each rising edge pops one byte)
//   Href, Vsyn      sensor line-valid / vertical sync (asynchronous)
//   Pclk, data      sensor pixel clock and pixel byte (asynchronous)
//   data_out        last popped byte
//   empty, full     FIFO status
//   level           bytes stored (AW+1 bits)
//   overflow        sticky: a byte was dropped since the last capture start
//   busy, done      FSM status (WAIT_VS/CAPTURE, DONE)
//   Xclk            sensor master clock, clk / (2*XCLK_HALF)
//   reset, PWDN     sensor reset (active-low) and power-down (active-high)
module cam_capture #(
  parameter int AW        = 10,
  parameter int XCLK_HALF = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          rd,
  input  logic          Href,
  input  logic          Vsyn,
  input  logic          Pclk,
  input  logic [7:0]    data,
  output logic [7:0]    data_out,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          busy,
  output logic          done,
  output logic          Xclk,
  output logic          reset,
  output logic          PWDN
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  localparam int CW = (XCLK_HALF > 1) ? $clog2(XCLK_HALF) : 1;
  localparam logic [CW-1:0] XLAST = CW'(XCLK_HALF - 1);
  localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   ONE   = {{AW{1'b0}}, 1'b1};

  state_t         state, state_next;
  logic           pclk_s1, pclk_s2, pclk_s3;
  logic           href_s1, href_s2;
  logic           vsyn_s1, vsyn_s2, vsyn_s3;
  logic [7:0]     data_s1, data_s2;
  logic           cap_s, cap_d, rd_s, rd_d;
  logic           pclk_rise, vs_rise, vs_fall, cap_rise, rd_rise;
  logic           start, wr_req, wr_en, pop;
  logic [AW:0]    wptr, rptr;
  logic [7:0]     mem [2**AW];
  logic [CW-1:0]  xcnt;
  logic           cam_on;

  // Synchronizers and request edge-detect registers. The request inputs get
  // a sampling flop plus an edge flop, so a held level fires exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_s3 <= 1'b0;
      href_s1 <= 1'b0; href_s2 <= 1'b0;
      vsyn_s1 <= 1'b0; vsyn_s2 <= 1'b0; vsyn_s3 <= 1'b0;
      data_s1 <= 8'd0; data_s2 <= 8'd0;
      cap_s   <= 1'b0; cap_d   <= 1'b0;
      rd_s    <= 1'b0; rd_d    <= 1'b0;
    end else begin
      pclk_s1 <= Pclk;    pclk_s2 <= pclk_s1; pclk_s3 <= pclk_s2;
      href_s1 <= Href;    href_s2 <= href_s1;
      vsyn_s1 <= Vsyn;    vsyn_s2 <= vsyn_s1; vsyn_s3 <= vsyn_s2;
      data_s1 <= data;    data_s2 <= data_s1;
      cap_s   <= capture; cap_d   <= cap_s;
      rd_s    <= rd;      rd_d    <= rd_s;
    end
  end

  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign vs_rise   = vsyn_s2 & ~vsyn_s3;
  assign vs_fall   = ~vsyn_s2 & vsyn_s3;
  assign cap_rise  = cap_s & ~cap_d;
  assign rd_rise   = rd_s & ~rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    wr_req     = 1'b0;
    case (state)
      IDLE: begin
        if (cap_rise) begin
          state_next = WAIT_VS;
          start      = 1'b1;
        end
      end
      // Waiting for the end of a Vsync pulse means the frame starts at line 0.
      WAIT_VS: if (vs_fall) state_next = CAPTURE;
      CAPTURE: begin
        wr_req = pclk_rise & href_s2;
        if (vs_rise) state_next = DONE;
      end
      DONE:    if (!cap_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign level = wptr - rptr;
  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign wr_en = wr_req & ~full;
  assign pop   = rd_rise & ~empty;
  assign busy  = (state == WAIT_VS) || (state == CAPTURE);
  assign done  = (state == DONE);

  // FIFO pointers, sticky overflow and the popped-byte register. The
  // full test uses the level before any same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      data_out <= 8'd0;
    end else if (start) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)       wptr     <= wptr + ONE;
      if (wr_req && full) overflow <= 1'b1;
      if (pop) begin
        rptr     <= rptr + ONE;
        data_out <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= data_s2;
  end

  // Free-running master clock divider; toggles on every XCLK_HALF-th edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xcnt <= '0;
      Xclk <= 1'b0;
    end else if (xcnt == XLAST) begin
      xcnt <= '0;
      Xclk <= ~Xclk;
    end else begin
      xcnt <= xcnt + CW'(1);
    end
  end

  // The sensor is held in reset and power-down only while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cam_on <= 1'b0;
    else     cam_on <= 1'b1;
  end

  assign reset = cam_on;
  assign PWDN  = ~cam_on;

endmodule

// File: tb/tb_cam_capture.sv
// Testbench for cam_capture (AW = 4, XCLK_HALF = 3). It drives a randomized
// sensor and request stimulus. Results are compared against a frame-level
// reference model: a byte queue filled when capturing with Href high and
// room left, and drained by pops.
module tb_cam_capture;
  localparam int AW    = 4;
  localparam int XH    = 3;
  localparam int DEPTH = 16;

  logic          clk, rst, capture, rd, Href, Vsyn, Pclk;
  logic [7:0]    data, data_out;
  logic          empty, full, overflow, busy, done, Xclk, reset, PWDN;
  logic [AW:0]   level;

  cam_capture #(.AW(AW), .XCLK_HALF(XH)) dut (
    .clk(clk), .rst(rst), .capture(capture), .rd(rd), .Href(Href),
    .Vsyn(Vsyn), .Pclk(Pclk), .data(data), .data_out(data_out),
    .empty(empty), .full(full), .level(level), .overflow(overflow),
    .busy(busy), .done(done), .Xclk(Xclk), .reset(reset), .PWDN(PWDN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [7:0] q [$];
  bit         m_cap;
  bit         m_ovf;
  logic [7:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_data_out"}, data_out, 0);
    chk({pfx, "_empty"},    empty,    1);
    chk({pfx, "_full"},     full,     0);
    chk({pfx, "_level"},    level,    0);
    chk({pfx, "_overflow"}, overflow, 0);
    chk({pfx, "_busy"},     busy,     0);
    chk({pfx, "_done"},     done,     0);
    chk({pfx, "_xclk"},     Xclk,     0);
    chk({pfx, "_reset"},    reset,    0);
    chk({pfx, "_pwdn"},     PWDN,     1);
  endtask

  // One pixel at Pclk = clk/4. With align_pop the rd edge is placed so the
  // pop lands on the same clk edge as this byte's write.
  task automatic send_byte(input logic [7:0] b, input bit h, input bit align_pop);
    bit was_full;
    data = b; Href = h; Pclk = 1'b0;
    step(2);
    Pclk = 1'b1;
    step(1);
    if (align_pop) rd = 1'b1;
    step(1);
    rd = 1'b0;
    was_full = (q.size() == DEPTH);
    if (align_pop && q.size() > 0) m_dout = q.pop_front();
    if (m_cap && h) begin
      if (!was_full) q.push_back(b);
      else           m_ovf = 1'b1;
    end
    if (align_pop) begin
      step(1);
      chk("align_level", level, q.size());
      chk("align_dout",  data_out, m_dout);
    end
  endtask

  task automatic pop_byte();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    step(1);
    if (q.size() > 0) m_dout = q.pop_front();
    chk("pop_dout",  data_out, m_dout);
    chk("pop_level", level, q.size());
    chk("pop_empty", empty, q.size() == 0);
  endtask

  task automatic start_capture();
    capture = 1'b1;
    step(3);
    q.delete();
    m_ovf = 1'b0;
    m_cap = 1'b0;
    chk("start_busy",     busy, 1);
    chk("start_level",    level, 0);
    chk("start_overflow", overflow, 0);
  endtask

  task automatic vs_pulse();
    Vsyn = 1'b1;
    step(3);
    Vsyn = 1'b0;
    step(3);
    m_cap = 1'b1;
  endtask

  task automatic frame(input int nlines, input int nbytes, input bit seq,
                       input logic [7:0] base, input int href_pct, input int align_at);
    int idx;
    logic [7:0] b;
    bit h;
    start_capture();
    // bytes before the first Vsync fall must not be stored
    for (int i = 0; i < 2; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    chk("prevs_level", level, 0);
    vs_pulse();
    idx = 0;
    for (int j = 0; j < nlines; j++) begin
      Href = 1'b0;
      step(3);
      for (int i = 0; i < nbytes; i++) begin
        b = seq ? 8'(base + idx) : 8'($urandom);
        h = ($urandom_range(99) < href_pct);
        send_byte(b, h, idx == align_at);
        idx++;
      end
      Href = 1'b0;
      step(3);
      if (j == 0) begin
        // a fresh capture edge during CAPTURE must be ignored
        capture = 1'b0;
        step(2);
        capture = 1'b1;
        step(3);
        chk("repulse_busy",  busy, 1);
        chk("repulse_level", level, q.size());
      end
    end
    Vsyn = 1'b1;
    step(3);
    m_cap = 1'b0;
    chk("frame_done",     done, 1);
    chk("frame_busy",     busy, 0);
    chk("frame_level",    level, q.size());
    chk("frame_full",     full, q.size() == DEPTH);
    chk("frame_overflow", overflow, m_ovf);
    Vsyn = 1'b0;
    capture = 1'b0;
    step(2);
    chk("idle_done", done, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; capture = 1'b0; rd = 1'b0; Href = 1'b0; Vsyn = 1'b0;
    Pclk = 1'b0; data = 8'd0;
    m_cap = 1'b0; m_ovf = 1'b0; m_dout = 8'd0;
    #2;
    chk_reset_vals("por");
    step(2);
    rst = 1'b0;
    step(1);
    chk("rel_reset", reset, 1);
    chk("rel_pwdn",  PWDN, 0);
    chk("xclk_e1", Xclk, 0);
    step(1); chk("xclk_e2", Xclk, 0);
    step(1); chk("xclk_e3", Xclk, 1);
    step(2); chk("xclk_e5", Xclk, 1);
    step(1); chk("xclk_e6", Xclk, 0);
    step(2); chk("xclk_e8", Xclk, 0);
    step(1); chk("xclk_e9", Xclk, 1);

    // deterministic frame: 2 lines x 4 bytes, 0x10..0x17
    frame(2, 4, 1'b1, 8'h10, 100, -1);
    for (int i = 0; i < 8; i++) pop_byte();
    pop_byte();
    chk("empty_pop_dout", data_out, 8'h17);

    // write and pop on the same edge at level 3
    frame(1, 6, 1'b1, 8'h40, 100, 3);
    while (q.size() > 0) pop_byte();

    // randomized frames with Href gating and partial drains
    for (int f = 0; f < 4; f++) begin
      frame($urandom_range(1, 3), $urandom_range(1, 5), 1'b0, 8'h00, 70, -1);
      n = $urandom_range(0, q.size());
      for (int i = 0; i < n; i++) pop_byte();
    end

    // overflow: one 20-byte line into a 16-byte FIFO
    frame(1, 20, 1'b1, 8'h80, 100, -1);
    for (int i = 0; i < 4; i++) pop_byte();
    start_capture();

    // asynchronous reset in the middle of a capture at level 5
    vs_pulse();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    step(3);
    chk("pre_rst_level", level, 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    step(2);
    rst = 1'b0;
    capture = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
